// File: rtl/snes_pad_responder.sv
// snes_pad_responder
// Device side of the SNES controller link. Captures the button vector while
// the host holds snes_latch high, then shifts it out active-low on snes_data,
// one bit per rising edge of snes_clk. Host pins are asynchronous and pass
// through two-flop synchronisers; edges come from a third registered copy.
//
// Handshake note: there is no valid/ready pair here. poll and short_read are
// single-cycle registered strobes. poll marks a completed latch (latch falling
// edge). short_read marks a new latch that cut off a transfer with fewer than
// 16 shifts. The two strobes are never asserted in the same cycle.
module snes_pad_responder #(
    parameter logic [11:0] TIMEOUT = 12'd2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] buttons,
    input  logic        snes_latch,
    input  logic        snes_clk,
    output logic        snes_data,
    output logic        poll,
    output logic        short_read,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [15:0] shreg, shreg_n;
    logic [4:0]  count, count_n;
    logic [11:0] to_cnt, to_cnt_n;
    logic        poll_n, short_n;

    logic latch_m, latch_s, latch_d;
    logic clk_m, clk_s, clk_d;

    logic        latch_rise, latch_fall, clk_rise;
    logic [15:0] loaded;

    // Two-flop synchronisers plus one delayed copy for edge detection.
    // Clock stages reset high because the host clock idles high, so leaving
    // reset never looks like a rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_m <= 1'b0;
            latch_s <= 1'b0;
            latch_d <= 1'b0;
            clk_m   <= 1'b1;
            clk_s   <= 1'b1;
            clk_d   <= 1'b1;
        end else begin
            latch_m <= snes_latch;
            latch_s <= latch_m;
            latch_d <= latch_s;
            clk_m   <= snes_clk;
            clk_s   <= clk_m;
            clk_d   <= clk_s;
        end
    end

    assign latch_rise = latch_s & ~latch_d;
    assign latch_fall = ~latch_s & latch_d;
    assign clk_rise   = clk_s & ~clk_d;

    // Upper four button bits do not exist on a real pad: always released.
    assign loaded = {4'b0000, buttons[11:0]};

    // State, shift register, counters and strobe registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            shreg      <= 16'd0;
            count      <= 5'd0;
            to_cnt     <= 12'd0;
            poll       <= 1'b0;
            short_read <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            count      <= count_n;
            to_cnt     <= to_cnt_n;
            poll       <= poll_n;
            short_read <= short_n;
        end
    end

    // Next-state logic. A latch rising edge wins over everything, including a
    // coincident clock edge, so the reload happens and that shift is dropped.
    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        count_n  = count;
        to_cnt_n = to_cnt;
        poll_n   = 1'b0;
        short_n  = 1'b0;
        if (latch_rise || (state == ST_IDLE && latch_s)) begin
            state_n  = ST_LOAD;
            shreg_n  = loaded;
            count_n  = 5'd0;
            to_cnt_n = 12'd0;
            short_n  = (state == ST_SHIFT) && (count < 5'd16);
        end else begin
            case (state)
                ST_IDLE: begin
                    shreg_n  = 16'd0;
                    count_n  = 5'd0;
                    to_cnt_n = 12'd0;
                end
                ST_LOAD: begin
                    if (latch_fall) begin
                        // A clock edge landing in this same cycle is ignored.
                        state_n = ST_SHIFT;
                        poll_n  = 1'b1;
                    end else begin
                        shreg_n  = loaded;
                        count_n  = 5'd0;
                        to_cnt_n = 12'd0;
                    end
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        shreg_n  = {1'b0, shreg[15:1]};
                        count_n  = count + 5'd1;
                        to_cnt_n = 12'd0;
                        if (count == 5'd15) begin
                            state_n = ST_DONE;
                        end
                    end else if (to_cnt == TIMEOUT) begin
                        state_n  = ST_IDLE;
                        shreg_n  = 16'd0;
                        count_n  = 5'd0;
                        to_cnt_n = 12'd0;
                    end else if (to_cnt != 12'hFFF) begin
                        to_cnt_n = to_cnt + 12'd1;
                    end
                end
                ST_DONE: begin
                    shreg_n = 16'd0;
                end
                default: begin
                    state_n = ST_IDLE;
                    shreg_n = 16'd0;
                end
            endcase
        end
    end

    assign snes_data = ~shreg[0];
    assign state_dbg = state;

endmodule
